// File: rtl/apb_ram_slave.sv
// apb_ram_slave: parametrised APB RAM target with wait states, PSLVERR on
// out-of-range / misaligned accesses, and abort handling.
// Optional feature macro: APB_RAM_PSTRB_EN enables APB4 byte strobes (pstrb).
// The setup phase is decoded while in IDLE and its outcome is registered at
// the setup edge, so the first access cycle already sees WAIT or READY.
module apb_ram_slave #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 0
) (
  input  logic                    clk,
  input  logic                    preset,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [DATA_WIDTH-1:0]   pwdata,
`ifdef APB_RAM_PSTRB_EN
  input  logic [DATA_WIDTH/8-1:0] pstrb,
`endif
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pready,
  output logic                    pslverr
);

  localparam int NB  = DATA_WIDTH / 8;
  localparam int LSB = (NB > 1) ? $clog2(NB) : 0;
  localparam int IW  = ADDR_WIDTH - LSB;
  localparam int MW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IW:0] DEPTH_X = (IW+1)'(DEPTH);
  localparam logic [3:0]  WS      = 4'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, WAIT, READY} state_t;

  state_t                state, state_n;
  logic [3:0]            cnt, cnt_n;
  logic                  start, done;
  logic [MW-1:0]         addr_q, addr_s;
  logic                  write_q, write_s;
  logic                  err_q, err_s, err_in, mis;
  logic [IW:0]           idx_x;
  logic                  enter_rd;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Extra top bit lets DEPTH == 2^IW be compared without overflow.
  assign idx_x = {1'b0, paddr[ADDR_WIDTH-1:LSB]};

  generate
    if (LSB > 0) begin : g_align
      assign mis = |paddr[LSB-1:0];
    end else begin : g_noalign
      assign mis = 1'b0;
    end
  endgenerate

  assign err_in = (idx_x >= DEPTH_X) | mis;

  // Next-state logic and transfer start/complete strobes.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    start   = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE: begin
        // penable without a preceding setup phase is ignored here
        if (psel && !penable) begin
          start   = 1'b1;
          cnt_n   = WS;
          state_n = (WS != 4'd0) ? WAIT : READY;
        end
      end
      WAIT: begin
        if (!psel)              state_n = IDLE;
        else if (cnt <= 4'd1)   state_n = READY;
        else                    cnt_n   = cnt - 4'd1;
      end
      READY: begin
        if (!psel) state_n = IDLE;
        else if (penable) begin
          done    = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // At the setup edge the live bus is used; afterwards only latched values.
  always_comb begin
    addr_s   = start ? paddr[LSB +: MW] : addr_q;
    write_s  = start ? pwrite : write_q;
    err_s    = start ? err_in : err_q;
    enter_rd = (state_n == READY) && (state != READY) && !write_s;
  end

  // State, latched request and registered response outputs.
  always_ff @(posedge clk or posedge preset) begin
    if (preset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      addr_q  <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      pready  <= 1'b0;
      pslverr <= 1'b0;
      prdata  <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      addr_q  <= addr_s;
      write_q <= write_s;
      err_q   <= err_s;
      pready  <= (state_n == READY);
      pslverr <= (state_n == READY) && err_s;
      if (enter_rd) prdata <= err_s ? '0 : mem[addr_s];
    end
  end

  // Memory array: cleared on reset, written only at the completion edge.
  always_ff @(posedge clk or posedge preset) begin
    if (preset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (done && write_q && !err_q) begin
`ifdef APB_RAM_PSTRB_EN
      for (int b = 0; b < NB; b++)
        if (pstrb[b]) mem[addr_q][8*b +: 8] <= pwdata[8*b +: 8];
`else
      mem[addr_q] <= pwdata;
`endif
    end
  end

endmodule

// File: tb/tb_apb_ram_slave.sv
// Bench for apb_ram_slave: one instance with no wait states, one with three.
module tb_apb_ram_slave;

`ifdef APB_RAM_PSTRB_EN
  localparam bit STRB_EN = 1'b1;
`else
  localparam bit STRB_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_v     [2];
  logic        psel_v    [2];
  logic        penable_v [2];
  logic        pwrite_v  [2];
  logic [31:0] paddr_v   [2];
  logic [31:0] pwdata_v  [2];
  logic [3:0]  pstrb_v   [2];
  logic [31:0] prdata_v  [2];
  logic        pready_v  [2];
  logic        pslverr_v [2];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [31:0] model [2][64];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  apb_ram_slave #(.WAIT_STATES(0)) u0 (
    .clk(clk), .preset(rst_v[0]), .psel(psel_v[0]), .penable(penable_v[0]),
    .pwrite(pwrite_v[0]), .paddr(paddr_v[0]), .pwdata(pwdata_v[0]),
`ifdef APB_RAM_PSTRB_EN
    .pstrb(pstrb_v[0]),
`endif
    .prdata(prdata_v[0]), .pready(pready_v[0]), .pslverr(pslverr_v[0]));

  apb_ram_slave #(.WAIT_STATES(3)) u3 (
    .clk(clk), .preset(rst_v[1]), .psel(psel_v[1]), .penable(penable_v[1]),
    .pwrite(pwrite_v[1]), .paddr(paddr_v[1]), .pwdata(pwdata_v[1]),
`ifdef APB_RAM_PSTRB_EN
    .pstrb(pstrb_v[1]),
`endif
    .prdata(prdata_v[1]), .pready(pready_v[1]), .pslverr(pslverr_v[1]));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic bit exp_err(input logic [31:0] a);
    return (a[31:2] >= 30'd64) || (a[1:0] != 2'b00);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    logic [3:0]  se;
    r  = old;
    se = STRB_EN ? s : 4'hF;
    for (int b = 0; b < 4; b++) if (se[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Full transfer; caller is at a negedge. Ends at the negedge after completion
  // with the bus idle, so a following call runs back-to-back.
  task automatic xfer(input int d, input bit wr, input logic [31:0] a,
                      input logic [31:0] dat, input logic [3:0] st,
                      output logic [31:0] rd, output logic er);
    int n, c0, ws;
    ws = (d == 0) ? 0 : 3;
    psel_v[d] = 1'b1; penable_v[d] = 1'b0; pwrite_v[d] = wr;
    paddr_v[d] = a; pwdata_v[d] = dat; pstrb_v[d] = st;
    c0 = cyc;
    @(negedge clk);
    penable_v[d] = 1'b1;
    n = 0;
    while (!pready_v[d] && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!pready_v[d]) chk("timeout", 0, 1);
    chk("wait_cycles", n, ws);
    rd = prdata_v[d];
    er = pslverr_v[d];
    @(negedge clk);
    chk("pready_drop", {pready_v[d], pslverr_v[d]}, 0);
    chk("xfer_cycles", cyc - c0, ws + 2);
    psel_v[d] = 1'b0; penable_v[d] = 1'b0;
  endtask

  // Model-checked transfer.
  task automatic mxfer(input int d, input bit wr, input logic [31:0] a,
                       input logic [31:0] dat, input logic [3:0] st);
    logic [31:0] rd;
    logic        er;
    bit          e;
    e = exp_err(a);
    xfer(d, wr, a, dat, st, rd, er);
    chk("pslverr", er, e);
    if (!wr) chk("prdata", rd, e ? 32'h0 : model[d][a[7:2]]);
    if (wr && !e) model[d][a[7:2]] = merge(model[d][a[7:2]], dat, st);
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    bit          err;
    logic [31:0] rd;
  } vec_t;

  vec_t tbl[10];

  initial begin
    logic [31:0] rd, a, dat;
    logic        er;
    bit          wr;
    int          d;

    for (int i = 0; i < 2; i++) begin
      rst_v[i] = 1'b1; psel_v[i] = 1'b0; penable_v[i] = 1'b0; pwrite_v[i] = 1'b0;
      paddr_v[i] = '0; pwdata_v[i] = '0; pstrb_v[i] = 4'hF;
      for (int j = 0; j < 64; j++) model[i][j] = '0;
    end

    tbl[0] = '{1, 32'h010, 32'hDEADBEEF, 0, 32'h0};
    tbl[1] = '{0, 32'h010, 32'h0,        0, 32'hDEADBEEF};
    tbl[2] = '{1, 32'h100, 32'h12345678, 1, 32'h0};
    tbl[3] = '{0, 32'h100, 32'h0,        1, 32'h0};
    tbl[4] = '{0, 32'h102, 32'h0,        1, 32'h0};
    tbl[5] = '{1, 32'h0FC, 32'hCAFEF00D, 0, 32'h0};
    tbl[6] = '{0, 32'h0FC, 32'h0,        0, 32'hCAFEF00D};
    tbl[7] = '{1, 32'h013, 32'h55555555, 1, 32'h0};
    tbl[8] = '{0, 32'h000, 32'h0,        0, 32'h0};
    tbl[9] = '{0, 32'h010, 32'h0,        0, 32'hDEADBEEF};

    repeat (3) @(negedge clk);
    rst_v[0] = 1'b0; rst_v[1] = 1'b0;
    for (int i = 0; i < 2; i++)
      chk("reset_outputs", {prdata_v[i], pready_v[i], pslverr_v[i]}, 0);

    // Directed table on the zero-wait instance, back-to-back
    for (int i = 0; i < 10; i++) begin
      xfer(0, tbl[i].wr, tbl[i].addr, tbl[i].data, 4'hF, rd, er);
      chk($sformatf("tbl%0d_err", i), er, tbl[i].err);
      if (!tbl[i].wr) chk($sformatf("tbl%0d_rd", i), rd, tbl[i].rd);
      if (tbl[i].wr && !tbl[i].err) model[0][tbl[i].addr[7:2]] = tbl[i].data;
    end

    // penable with no setup phase is ignored
    psel_v[0] = 1'b1; penable_v[0] = 1'b1; pwrite_v[0] = 1'b1;
    paddr_v[0] = 32'h10; pwdata_v[0] = 32'h0;
    repeat (3) begin
      @(negedge clk);
      chk("no_setup_pready", pready_v[0], 0);
    end
    psel_v[0] = 1'b0; penable_v[0] = 1'b0;
    @(negedge clk);
    mxfer(0, 0, 32'h10, 0, 4'hF);

    // Abort in READY on the zero-wait instance
    psel_v[0] = 1'b1; penable_v[0] = 1'b0; pwrite_v[0] = 1'b1;
    paddr_v[0] = 32'h10; pwdata_v[0] = 32'h0BADF00D;
    @(negedge clk);
    penable_v[0] = 1'b1;
    chk("ready_before_abort", pready_v[0], 1);
    psel_v[0] = 1'b0; penable_v[0] = 1'b0;
    @(negedge clk);
    chk("abort_ready_clear", {pready_v[0], pslverr_v[0]}, 0);
    mxfer(0, 0, 32'h10, 0, 4'hF);

    // Three-wait instance: basic write/read then abort during WAIT
    mxfer(1, 1, 32'h10, 32'hDEADBEEF, 4'hF);
    mxfer(1, 0, 32'h10, 0, 4'hF);
    mxfer(1, 1, 32'h20, 32'hA5A5A5A5, 4'hF);
    psel_v[1] = 1'b1; penable_v[1] = 1'b0; pwrite_v[1] = 1'b1;
    paddr_v[1] = 32'h20; pwdata_v[1] = 32'h5A5A5A5A;
    @(negedge clk);
    penable_v[1] = 1'b1;
    @(negedge clk);
    psel_v[1] = 1'b0; penable_v[1] = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("abort_wait_pready", pready_v[1], 0);
    end
    mxfer(1, 0, 32'h20, 0, 4'hF);

    // Reset asserted mid-WAIT; prdata currently holds 0xA5A5A5A5
    psel_v[1] = 1'b1; penable_v[1] = 1'b0; pwrite_v[1] = 1'b1;
    paddr_v[1] = 32'h10; pwdata_v[1] = 32'h77777777;
    @(negedge clk);
    penable_v[1] = 1'b1;
    @(negedge clk);
    rst_v[1] = 1'b1;
    #1;
    chk("midwait_reset", {prdata_v[1], pready_v[1], pslverr_v[1]}, 0);
    psel_v[1] = 1'b0; penable_v[1] = 1'b0;
    @(negedge clk);
    rst_v[1] = 1'b0;
    for (int j = 0; j < 64; j++) model[1][j] = '0;
    mxfer(1, 0, 32'h0, 0, 4'hF);
    mxfer(1, 0, 32'h10, 0, 4'hF);

`ifdef APB_RAM_PSTRB_EN
    mxfer(0, 1, 32'h30, 32'hFFFFFFFF, 4'hF);
    mxfer(0, 1, 32'h30, 32'h11223344, 4'b0101);
    xfer(0, 0, 32'h30, 32'h0, 4'h0, rd, er);
    chk("pstrb_merge", rd, 32'hFF22FF44);
    mxfer(0, 1, 32'h30, 32'h00000000, 4'b0000);
    mxfer(0, 0, 32'h30, 0, 4'hF);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 200; i++) begin
      d   = i % 2;
      wr  = $urandom_range(0, 1);
      a   = $urandom_range(0, 32'h10F);
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      dat = $urandom;
      mxfer(d, wr, a, dat, 4'($urandom_range(0, 15)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
